// File: rtl/sap_ctrl_pkg.sv
// Shared control-path definitions for the SAP sequencers and the instruction decoder.
// Holds the AH/AL select encodings, the multiply FSM states and the aluNacc control word.
package sap_ctrl_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_H,
        LOAD_L,
        CLR_H,
        ADD,
        SHIFT,
        DONE
    } mul_state_t;

    typedef struct packed {
        logic       ah_inen;
        logic       ah_reset;
        logic [1:0] hs;
        logic [1:0] ls;
        logic       s_mul;
        logic       busy;
        logic       done;
    } ctrl_word_t;

    // Moore output word driven while the sequencer sits in state s.
    function automatic ctrl_word_t ctrl_word(input mul_state_t s);
        ctrl_word_t w;
        w = '0;
        case (s)
            LOAD_H: begin
                w.ah_inen = 1'b1;
                w.hs      = SEL_LOAD;
                w.busy    = 1'b1;
            end
            LOAD_L: begin
                w.ls   = SEL_LOAD;
                w.busy = 1'b1;
            end
            CLR_H: begin
                w.ah_reset = 1'b1;
                w.busy     = 1'b1;
            end
            ADD: begin
                w.hs    = SEL_LOAD;
                w.s_mul = 1'b1;
                w.busy  = 1'b1;
            end
            SHIFT: begin
                w.hs   = SEL_SHR;
                w.ls   = SEL_SHR;
                w.busy = 1'b1;
            end
            DONE: begin
                w.done = 1'b1;
                w.busy = 1'b1;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/mul_sequencer.sv
// Turns a single start request into the shift-add multiply (or load-only) control
// word sequence for aluNacc. Outputs are registered alongside the state they belong to.
module mul_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       mode,
    output logic       ah_inen,
    output logic       ah_reset,
    output logic [1:0] hs,
    output logic [1:0] ls,
    output logic       s_mul,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    mul_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             mode_q;
    ctrl_word_t       cw;

    // State, counter and output word advance together so the word always matches the state.
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= 1'b0;
            cw     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD_H;
                        mode_q <= mode;
                        cw     <= ctrl_word(LOAD_H);
                    end else begin
                        cw <= ctrl_word(IDLE);
                    end
                end
                LOAD_H: begin
                    state <= LOAD_L;
                    cw    <= ctrl_word(LOAD_L);
                end
                LOAD_L: begin
                    if (mode_q) begin
                        state <= DONE;
                        cw    <= ctrl_word(DONE);
                    end else begin
                        state <= CLR_H;
                        cw    <= ctrl_word(CLR_H);
                    end
                end
                CLR_H: begin
                    cnt   <= '0;
                    state <= ADD;
                    cw    <= ctrl_word(ADD);
                end
                ADD: begin
                    state <= SHIFT;
                    cw    <= ctrl_word(SHIFT);
                end
                SHIFT: begin
                    cnt <= cnt + CNT_W'(1);
                    // cnt still holds the pairs completed before this one
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= DONE;
                        cw    <= ctrl_word(DONE);
                    end else begin
                        state <= ADD;
                        cw    <= ctrl_word(ADD);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cw    <= ctrl_word(IDLE);
                end
                default: begin
                    state <= IDLE;
                    cw    <= '0;
                end
            endcase
        end
    end

    assign ah_inen  = cw.ah_inen;
    assign ah_reset = cw.ah_reset;
    assign hs       = cw.hs;
    assign ls       = cw.ls;
    assign s_mul    = cw.s_mul;
    assign busy     = cw.busy;
    assign done     = cw.done;

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Control-side stage directly upstream of the ALU/accumulator (aluNacc).
- Converts a single `start` request into the cycle-exact control word sequence for the accumulator's shift-add multiply: load AH, copy to AL, clear AH, then WIDTH add/shift pairs.
- Replaces hand-sequenced T3..T10 control from the instruction decoder; its outputs connect one-to-one to the aluNacc control inputs of the same name.

Parameters:
- WIDTH, 4, operand width in bits; number of add/shift iterations.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = multiply, 1 = load-only (AH then AL, no arithmetic).
- ah_inen  out  1  enable bus_in into AH path.
- ah_reset  out  1  clear AH.
- hs  out  2  AH select: 00 hold, 01 shift right, 11 load.
- ls  out  2  AL select: 00 hold, 01 shift right, 11 load.
- s_mul  out  1  ALU multiply-step select (add B if acc LSB set).
- busy  out  1  high from first control cycle through DONE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset and clock: one clock; reset is synchronous and active-high, named `clk` and `clr`.
  - `clr` sampled high returns the FSM to IDLE and zeros all outputs and the counter on the next edge, including mid-operation.
  - No partial sequence resumes after reset.
- Output timing: all outputs are registered (Moore); no combinational path from `start` to any output.
- States and output words (outputs not listed are 0):
  - IDLE: all outputs 0. `start`=1 -> LOAD_H.
  - LOAD_H: ah_inen=1, hs=11, busy=1. -> LOAD_L.
  - LOAD_L: ls=11, busy=1. mode=1 -> DONE; mode=0 -> CLR_H.
  - CLR_H: ah_reset=1, busy=1. cnt<=0. -> ADD.
  - ADD: hs=11, s_mul=1, busy=1. -> SHIFT.
  - SHIFT: hs=01, ls=01, busy=1. cnt<=cnt+1. If cnt==WIDTH-1 -> DONE, else -> ADD.
  - DONE: done=1, busy=1. -> IDLE.
- Latency:
  - `start` sampled at edge 0 -> LOAD_H outputs visible after edge 1.
  - Multiply: DONE visible after edge 3+2*WIDTH+1 = edge 12 for WIDTH=4.
  - Load-only: DONE visible after edge 3.
- `mode` is latched on the edge that accepts `start`; later changes are ignored.
- `start` while not in IDLE (including DONE) is ignored and not queued.
- Back-to-back: `start` held high continuously gives one DONE cycle, one IDLE cycle, then a new LOAD_H.
- Counter: counts completed ADD/SHIFT pairs; never exceeds WIDTH-1 at a compare; cleared in CLR_H and on reset.
- hs and ls never take 10; the encoding is reserved and never driven.

Decomposition:
- Shared package `sap_ctrl_pkg`:
  - hs/ls encodings: SEL_HOLD=2'b00, SEL_SHR=2'b01, SEL_LOAD=2'b11.
  - State enum `mul_state_t` {IDLE, LOAD_H, LOAD_L, CLR_H, ADD, SHIFT, DONE}.
  - Control word struct reused by the main instruction decoder.
- Single module, no sub-module; state register, counter and output register in one file.

Test Plan:
- Reset: clr=1 for 2 cycles with start=1 -> all outputs 0, busy=0; first LOAD_H appears only after clr drops.
- Multiply trace, WIDTH=4, start pulse, mode=0 -> per-cycle (hs,ls,s_mul,ah_inen,ah_reset):
  - (11,00,0,1,0), (00,11,0,0,0), (00,00,0,0,1);
  - then 4x[(11,00,1,0,0),(01,01,0,0,0)];
  - then done=1 for exactly one cycle at cycle 12.
- End-to-end with aluNacc, bus_in=4'b0011, breg_in=4'b0101 -> acc_out=8'h0F when done=1; zero_flag=0.
- Load-only, mode=1 -> LOAD_H, LOAD_L, then done=1 on cycle 3; s_mul and ah_reset never asserted.
- Abort: clr at cycle 6 (mid ADD) -> outputs 0 next cycle, busy=0, no done pulse.
- Ignore and back-to-back: start pulses during busy cause no restart and no extra done; start held high -> exactly one IDLE cycle between DONE and the next LOAD_H.
